sw_hw_mailbox: RTL and testbench
================================

// Module: sw_hw_mailbox
// PURPOSE
//  Hardware end of the NIOS PIO handshake (to_hw_port/to_hw_sig, to_sw_port/to_sw_sig), generalised to multi-word messages.
//  Assembles IN_WORDS words written by software into one wide message for a hardware engine (e.g. AES core).
//  Captures the engine's wide result and returns it to software as OUT_WORDS words over the same PIO pair.
//  Sits between the nios_system PIO exports and the accelerator; runs in the NIOS clock domain (no synchronisers).
// PARAMETERS
//  WORD_W    32  PIO word width
//  IN_WORDS  4   words per SW->HW message (>=1)
//  OUT_WORDS 4   words per HW->SW result (>=1)
// PORTS
//  Clk        in   1                   system clock, all logic rising-edge
//  Reset      in   1                   synchronous, active-high
//  to_hw_port in   WORD_W              SW data word
//  to_hw_sig  in   2                   SW command: 00 IDLE, 01 WRITE, 10 READ, 11 ABORT
//  to_sw_port out  WORD_W              result word to SW
//  to_sw_sig  out  2                   HW status: 00 IDLE, 01 ACK, 10 RES_RDY, 11 ERROR
//  msg_data   out  IN_WORDS*WORD_W     assembled message; word 0 in bits [WORD_W-1:0]
//  msg_valid  out  1                   message valid (valid/ready)
//  msg_ready  in   1                   engine accepts message
//  res_data   in   OUT_WORDS*WORD_W    engine result; word 0 in LSBs
//  res_valid  in   1                   result valid
//  res_ready  out  1                   mailbox accepts result
//  busy       out  1                   state != IDLE
//  proto_err  out  1                   sticky protocol-error flag, cleared by Reset or ABORT
// BEHAVIOUR
//  All outputs registered; Reset -> state IDLE, counters 0, all outputs 0, buffers 0.
//  States: IDLE, WR_ACK, DISPATCH, WAIT_RES, RES_AVAIL, RD_ACK, ERR.
//  IDLE: WRITE -> latch to_hw_port into in_buf[wcnt], to_sw_sig=ACK next cycle, go WR_ACK.
//    READ -> ERR (to_sw_sig=11, proto_err=1). IDLE/ABORT -> stay.
//  WR_ACK: hold ACK until to_hw_sig==IDLE; then to_sw_sig=00 next cycle, wcnt++;
//    if wcnt was IN_WORDS-1: wcnt=0, msg_valid=1, go DISPATCH; else IDLE. READ here -> ERR.
//  DISPATCH: msg_data/msg_valid stable until msg_ready sampled 1; then msg_valid=0, res_ready=1, go WAIT_RES.
//  WAIT_RES: on res_valid&res_ready latch res_data into out_buf, res_ready=0, to_sw_port=out word 0,
//    to_sw_sig=RES_RDY, go RES_AVAIL. WRITE/READ during DISPATCH/WAIT_RES: ignored, proto_err=1.
//  RES_AVAIL: READ -> to_sw_sig=ACK next cycle (to_sw_port already = word rcnt), go RD_ACK. WRITE -> ERR.
//  RD_ACK: on IDLE, rcnt++; if last word: rcnt=0, to_sw_sig=00, to_sw_port=0, go IDLE;
//    else to_sw_port=word rcnt+1, to_sw_sig=RES_RDY, go RES_AVAIL.
//  ERR: to_sw_sig=11 held; leaves only on ABORT.
//  ABORT (any state except DISPATCH/WAIT_RES): next cycle state IDLE, counters 0, to_sw_sig=00, proto_err=0.
//  ABORT in DISPATCH/WAIT_RES: pending flag set; valid/ready handshake completes normally,
//    result is discarded (not exposed), then IDLE. Never drops msg_valid before msg_ready.
//  Latency: command sample to to_sw_sig change = 1 cycle. msg_valid rises 1 cycle after final IDLE.
//  Simultaneous msg_ready on msg_valid's first cycle: accepted, DISPATCH lasts 1 cycle.
//  Reset mid-message: partial words discarded; SW must restart from word 0.
//  Counters sized $clog2 of max(IN_WORDS,OUT_WORDS)+1; no wrap beyond last index.
// STRUCTURE
//  Package sw_hw_mailbox_pkg: state enum, CMD_IDLE/WRITE/READ/ABORT, STS_IDLE/ACK/RES_RDY/ERROR constants.
//  Sub-module mailbox_word_buf (DEPTH, WORD_W): register array, indexed write, flat wide read/load;
//    instantiated twice (in_buf with indexed write, out_buf with wide parallel load).
//  Top: FSM + counters + output registers.
// TESTING
//  1. Write 4 words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF -> msg_data=0xCCDDEEFF_8899AABB_44556677_00112233, msg_valid 1 cycle after 4th IDLE.
//  2. msg_ready held 0 for 10 cycles -> msg_valid and msg_data stable; then accept -> res_ready=1 next cycle.
//  3. Engine returns 0xDEADBEEF_..._01234567 -> to_sw_sig=10, to_sw_port=0x01234567; 4 READ/IDLE pairs yield words 0..3, then to_sw_sig=00, busy=0.
//  4. READ in IDLE -> to_sw_sig=11, proto_err=1; ABORT -> both 0 next cycle, state IDLE.
//  5. ABORT during WAIT_RES -> result consumed on res_valid, to_sw_sig stays 00, back to IDLE; next write starts at word 0.
//  6. Reset after 2 of 4 words written -> all outputs 0; 4 fresh writes produce message with only new words.

Source files
------------

// File: rtl/sw_hw_mailbox_pkg.sv
// Shared types and command/status codes for the SW<->HW PIO mailbox.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sw_hw_mailbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_ACK    = 3'd1,
    ST_DISPATCH  = 3'd2,
    ST_WAIT_RES  = 3'd3,
    ST_RES_AVAIL = 3'd4,
    ST_RD_ACK    = 3'd5,
    ST_ERR       = 3'd6
  } mbox_state_t;

  // Software command on to_hw_sig
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  // Hardware status on to_sw_sig
  localparam logic [1:0] STS_IDLE    = 2'b00;
  localparam logic [1:0] STS_ACK     = 2'b01;
  localparam logic [1:0] STS_RES_RDY = 2'b10;
  localparam logic [1:0] STS_ERROR   = 2'b11;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mailbox_word_buf.sv
// Word register array: indexed single-word write, wide parallel load, flat wide read.
// Latency: write/load visible on o_rd_dat one cycle after the enable.
// Backpressure: none; always accepts, a parallel load wins over an indexed write.
module mailbox_word_buf #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_en,
  input  logic [IDX_W-1:0]        i_wr_idx,
  input  logic [WORD_W-1:0]       i_wr_dat,
  input  logic                    i_ld_en,
  input  logic [DEPTH*WORD_W-1:0] i_ld_dat,
  output logic [DEPTH*WORD_W-1:0] o_rd_dat
);

  logic [DEPTH*WORD_W-1:0] r_mem;

  // Storage: synchronous clear, whole-buffer load, or single indexed word write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem <= '0;
    end else if (i_ld_en) begin
      r_mem <= i_ld_dat;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
          r_mem[i*WORD_W +: WORD_W] <= i_wr_dat;
        end
      end
    end
  end

  assign o_rd_dat = r_mem;

endmodule

// File: rtl/sw_hw_mailbox.sv
// PIO mailbox: gathers IN_WORDS software words into one engine message, returns OUT_WORDS result words.
// Latency: 1 cycle from command sample to status change; msg_valid rises 1 cycle after the last write's IDLE.
// Backpressure: msg_valid held until msg_ready; res_ready held until res_valid; SW paced by ACK/IDLE handshake.
module sw_hw_mailbox
  import sw_hw_mailbox_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int IN_WORDS  = 4,
  parameter int OUT_WORDS = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [WORD_W-1:0]           to_hw_port,
  input  logic [1:0]                  to_hw_sig,
  output logic [WORD_W-1:0]           to_sw_port,
  output logic [1:0]                  to_sw_sig,
  output logic [IN_WORDS*WORD_W-1:0]  msg_data,
  output logic                        msg_valid,
  input  logic                        msg_ready,
  input  logic [OUT_WORDS*WORD_W-1:0] res_data,
  input  logic                        res_valid,
  output logic                        res_ready,
  output logic                        busy,
  output logic                        proto_err
);

  localparam int CNT_W    = $clog2(max_i(IN_WORDS, OUT_WORDS) + 1);
  localparam int IN_IDX_W = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int OUT_IDX_W = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  mbox_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_wcnt, w_wcnt_nxt;
  logic [CNT_W-1:0]  r_rcnt, w_rcnt_nxt;
  logic [1:0]        r_sts, w_sts_nxt;
  logic [WORD_W-1:0] r_port, w_port_nxt;
  logic              r_msg_vld, w_msg_vld_nxt;
  logic              r_res_rdy, w_res_rdy_nxt;
  logic              r_perr, w_perr_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_busy;

  logic                        w_in_wr;
  logic                        w_out_ld;
  logic                        w_in_flight;
  logic                        w_abort_now;
  logic [WORD_W-1:0]           w_next_word;
  logic [IN_WORDS*WORD_W-1:0]  w_in_flat;
  logic [OUT_WORDS*WORD_W-1:0] w_out_flat;

  mailbox_word_buf #(.DEPTH(IN_WORDS), .WORD_W(WORD_W)) u_in_buf (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_wr_en  (w_in_wr),
    .i_wr_idx (r_wcnt[IN_IDX_W-1:0]),
    .i_wr_dat (to_hw_port),
    .i_ld_en  (1'b0),
    .i_ld_dat ('0),
    .o_rd_dat (w_in_flat)
  );

  mailbox_word_buf #(.DEPTH(OUT_WORDS), .WORD_W(WORD_W)) u_out_buf (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_wr_en  (1'b0),
    .i_wr_idx ('0),
    .i_wr_dat ('0),
    .i_ld_en  (w_out_ld),
    .i_ld_dat (res_data),
    .o_rd_dat (w_out_flat)
  );

  // Result word that follows the one SW just read
  always_comb begin
    w_next_word = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if ((r_rcnt + CNT_W'(1)) == CNT_W'(i)) begin
        w_next_word = w_out_flat[i*WORD_W +: WORD_W];
      end
    end
  end

  // Next-state and next-output decode; ABORT is deferred while an engine handshake is open
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_rcnt_nxt    = r_rcnt;
    w_sts_nxt     = r_sts;
    w_port_nxt    = r_port;
    w_msg_vld_nxt = r_msg_vld;
    w_res_rdy_nxt = r_res_rdy;
    w_perr_nxt    = r_perr;
    w_pend_nxt    = r_pend;
    w_in_wr       = 1'b0;
    w_out_ld      = 1'b0;
    w_in_flight   = (r_state == ST_DISPATCH) || (r_state == ST_WAIT_RES);
    w_abort_now   = r_pend || (to_hw_sig == CMD_ABORT);

    if ((to_hw_sig == CMD_ABORT) && !w_in_flight) begin
      w_state_nxt = ST_IDLE;
      w_wcnt_nxt  = '0;
      w_rcnt_nxt  = '0;
      w_sts_nxt   = STS_IDLE;
      w_port_nxt  = '0;
      w_perr_nxt  = 1'b0;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (to_hw_sig == CMD_WRITE) begin
            w_in_wr     = 1'b1;
            w_sts_nxt   = STS_ACK;
            w_state_nxt = ST_WR_ACK;
          end else if (to_hw_sig == CMD_READ) begin
            w_sts_nxt   = STS_ERROR;
            w_perr_nxt  = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end
        ST_WR_ACK: begin
          if (to_hw_sig == CMD_IDLE) begin
            w_sts_nxt = STS_IDLE;
            if (r_wcnt == CNT_W'(IN_WORDS - 1)) begin
              w_wcnt_nxt    = '0;
              w_msg_vld_nxt = 1'b1;
              w_state_nxt   = ST_DISPATCH;
            end else begin
              w_wcnt_nxt  = r_wcnt + CNT_W'(1);
              w_state_nxt = ST_IDLE;
            end
          end else if (to_hw_sig == CMD_READ) begin
            w_sts_nxt   = STS_ERROR;
            w_perr_nxt  = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end
        ST_DISPATCH: begin
          if (to_hw_sig == CMD_ABORT) begin
            w_pend_nxt = 1'b1;
          end else if (to_hw_sig != CMD_IDLE) begin
            w_perr_nxt = 1'b1;
          end
          if (msg_ready) begin
            w_msg_vld_nxt = 1'b0;
            w_res_rdy_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (to_hw_sig == CMD_ABORT) begin
            w_pend_nxt = 1'b1;
          end else if (to_hw_sig != CMD_IDLE) begin
            w_perr_nxt = 1'b1;
          end
          if (res_valid && r_res_rdy) begin
            w_res_rdy_nxt = 1'b0;
            if (w_abort_now) begin
              // Aborted exchange: consume the result but never show it to SW
              w_state_nxt = ST_IDLE;
              w_wcnt_nxt  = '0;
              w_rcnt_nxt  = '0;
              w_sts_nxt   = STS_IDLE;
              w_port_nxt  = '0;
              w_perr_nxt  = 1'b0;
              w_pend_nxt  = 1'b0;
            end else begin
              w_out_ld    = 1'b1;
              w_port_nxt  = res_data[WORD_W-1:0];
              w_sts_nxt   = STS_RES_RDY;
              w_state_nxt = ST_RES_AVAIL;
            end
          end
        end
        ST_RES_AVAIL: begin
          if (to_hw_sig == CMD_READ) begin
            w_sts_nxt   = STS_ACK;
            w_state_nxt = ST_RD_ACK;
          end else if (to_hw_sig == CMD_WRITE) begin
            w_sts_nxt   = STS_ERROR;
            w_perr_nxt  = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end
        ST_RD_ACK: begin
          if (to_hw_sig == CMD_IDLE) begin
            if (r_rcnt == CNT_W'(OUT_WORDS - 1)) begin
              w_rcnt_nxt  = '0;
              w_sts_nxt   = STS_IDLE;
              w_port_nxt  = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_rcnt_nxt  = r_rcnt + CNT_W'(1);
              w_port_nxt  = w_next_word;
              w_sts_nxt   = STS_RES_RDY;
              w_state_nxt = ST_RES_AVAIL;
            end
          end else if (to_hw_sig == CMD_WRITE) begin
            w_sts_nxt   = STS_ERROR;
            w_perr_nxt  = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end
        ST_ERR: begin
          w_sts_nxt = STS_ERROR;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_sts     <= STS_IDLE;
      r_port    <= '0;
      r_msg_vld <= 1'b0;
      r_res_rdy <= 1'b0;
      r_perr    <= 1'b0;
      r_pend    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_sts     <= w_sts_nxt;
      r_port    <= w_port_nxt;
      r_msg_vld <= w_msg_vld_nxt;
      r_res_rdy <= w_res_rdy_nxt;
      r_perr    <= w_perr_nxt;
      r_pend    <= w_pend_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign to_sw_port = r_port;
  assign to_sw_sig  = r_sts;
  assign msg_data   = w_in_flat;
  assign msg_valid  = r_msg_vld;
  assign res_ready  = r_res_rdy;
  assign busy       = r_busy;
  assign proto_err  = r_perr;

endmodule

// File: tb/tb_sw_hw_mailbox.sv
// Bench for the PIO mailbox: directed scenarios plus randomized full transactions.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: engine stalls on msg_ready/res_valid are randomized.
module tb_sw_hw_mailbox;

  localparam logic [1:0] C_IDLE = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_ABORT = 2'b11;
  localparam logic [1:0] S_IDLE = 2'b00, S_ACK = 2'b01, S_RES = 2'b10, S_ERR = 2'b11;

  logic         Clk;
  logic         Reset;
  logic [31:0]  to_hw_port;
  logic [1:0]   to_hw_sig;
  logic [31:0]  to_sw_port;
  logic [1:0]   to_sw_sig;
  logic [127:0] msg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic [127:0] res_data;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  logic         proto_err;

  int n_checks = 0;
  int n_errs   = 0;

  sw_hw_mailbox #(.WORD_W(32), .IN_WORDS(4), .OUT_WORDS(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .to_hw_port (to_hw_port),
    .to_hw_sig  (to_hw_sig),
    .to_sw_port (to_sw_port),
    .to_sw_sig  (to_sw_sig),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: a message is the written words in order, word 0 in the LSBs
  function automatic logic [127:0] pack4(input logic [31:0] w [4]);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = w[i];
    return r;
  endfunction

  // SW side: one WRITE/ACK/IDLE/IDLE exchange, bounded
  task automatic sw_write(input logic [31:0] w, output bit ok);
    int n;
    ok = 1;
    to_hw_port = w;
    to_hw_sig  = C_WRITE;
    n = 0;
    do begin tick(); n++; end while (to_sw_sig != S_ACK && n < 20);
    if (to_sw_sig != S_ACK) ok = 0;
    to_hw_sig = C_IDLE;
    n = 0;
    do begin tick(); n++; end while (to_sw_sig != S_IDLE && n < 20);
    if (to_sw_sig != S_IDLE) ok = 0;
  endtask

  // SW side: one READ/ACK/IDLE exchange, bounded; word captured while ACK is shown
  task automatic sw_read(output logic [31:0] w, output bit ok);
    int n;
    ok = 1;
    to_hw_sig = C_READ;
    n = 0;
    do begin tick(); n++; end while (to_sw_sig != S_ACK && n < 20);
    if (to_sw_sig != S_ACK) ok = 0;
    w = to_sw_port;
    to_hw_sig = C_IDLE;
    n = 0;
    do begin tick(); n++; end while (to_sw_sig == S_ACK && n < 20);
    if (to_sw_sig == S_ACK) ok = 0;
  endtask

  task automatic test_reset();
    Reset = 1; to_hw_port = '0; to_hw_sig = C_IDLE; msg_ready = 0; res_data = '0; res_valid = 0;
    tick(); tick();
    Reset = 0;
    n_checks++; if (to_sw_sig !== S_IDLE) begin n_errs++; $display("FAIL rst_sts got %b exp %b", to_sw_sig, S_IDLE); end
    n_checks++; if (to_sw_port !== 32'h0) begin n_errs++; $display("FAIL rst_port got %h exp 0", to_sw_port); end
    n_checks++; if (msg_data !== 128'h0) begin n_errs++; $display("FAIL rst_msg got %h exp 0", msg_data); end
    n_checks++; if ({msg_valid, res_ready, busy, proto_err} !== 4'b0) begin
      n_errs++; $display("FAIL rst_flags got %b exp 0000", {msg_valid, res_ready, busy, proto_err}); end
  endtask

  task automatic test_write_msg();
    logic [31:0] w [4];
    bit ok;
    w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    for (int i = 0; i < 4; i++) begin
      sw_write(w[i], ok);
      n_checks++; if (!ok) begin n_errs++; $display("FAIL wr_handshake word %0d got timeout exp ACK/IDLE", i); end
      if (i < 3) begin
        n_checks++; if (msg_valid !== 1'b0) begin n_errs++; $display("FAIL wr_early_valid word %0d got %b exp 0", i, msg_valid); end
      end
    end
    n_checks++; if (msg_valid !== 1'b1) begin n_errs++; $display("FAIL wr_valid got %b exp 1", msg_valid); end
    n_checks++; if (msg_data !== 128'hCCDDEEFF_8899AABB_44556677_00112233) begin
      n_errs++; $display("FAIL wr_msg got %h exp %h", msg_data, 128'hCCDDEEFF_8899AABB_44556677_00112233); end
    n_checks++; if (busy !== 1'b1) begin n_errs++; $display("FAIL wr_busy got %b exp 1", busy); end
  endtask

  task automatic test_dispatch_stall();
    logic [127:0] exp_msg;
    exp_msg = 128'hCCDDEEFF_8899AABB_44556677_00112233;
    msg_ready = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin to_hw_sig = C_WRITE; to_hw_port = $urandom; end
      else to_hw_sig = C_IDLE;
      tick();
      n_checks++; if (msg_valid !== 1'b1 || msg_data !== exp_msg) begin
        n_errs++; $display("FAIL stall_hold cyc %0d got v=%b d=%h exp v=1 d=%h", c, msg_valid, msg_data, exp_msg); end
    end
    n_checks++; if (proto_err !== 1'b1 || to_sw_sig !== S_IDLE) begin
      n_errs++; $display("FAIL busy_write got perr=%b sts=%b exp perr=1 sts=00", proto_err, to_sw_sig); end
    msg_ready = 1;
    tick();
    msg_ready = 0;
    n_checks++; if (msg_valid !== 1'b0 || res_ready !== 1'b1) begin
      n_errs++; $display("FAIL accept got v=%b rr=%b exp v=0 rr=1", msg_valid, res_ready); end
  endtask

  task automatic test_result_read();
    logic [127:0] res;
    logic [31:0] rd;
    bit ok;
    res = 128'hDEADBEEF_CAFEF00D_76543210_01234567;
    repeat (3) tick();
    n_checks++; if (res_ready !== 1'b1) begin n_errs++; $display("FAIL res_ready_hold got %b exp 1", res_ready); end
    res_data = res; res_valid = 1;
    tick();
    res_valid = 0;
    n_checks++; if (to_sw_sig !== S_RES || to_sw_port !== 32'h01234567 || res_ready !== 1'b0) begin
      n_errs++; $display("FAIL res_cap got sts=%b port=%h rr=%b exp sts=10 port=01234567 rr=0", to_sw_sig, to_sw_port, res_ready); end
    for (int i = 0; i < 4; i++) begin
      sw_read(rd, ok);
      n_checks++; if (!ok || rd !== res[i*32 +: 32]) begin
        n_errs++; $display("FAIL rd_word %0d got %h ok=%0d exp %h", i, rd, ok, res[i*32 +: 32]); end
      if (i < 3) begin
        n_checks++; if (to_sw_sig !== S_RES) begin n_errs++; $display("FAIL rd_next_sts %0d got %b exp 10", i, to_sw_sig); end
      end
    end
    n_checks++; if (to_sw_sig !== S_IDLE || busy !== 1'b0 || to_sw_port !== 32'h0) begin
      n_errs++; $display("FAIL rd_done got sts=%b busy=%b port=%h exp 00/0/0", to_sw_sig, busy, to_sw_port); end
    n_checks++; if (proto_err !== 1'b1) begin n_errs++; $display("FAIL perr_sticky got %b exp 1", proto_err); end
  endtask

  task automatic test_read_in_idle();
    to_hw_sig = C_READ;
    tick();
    n_checks++; if (to_sw_sig !== S_ERR || proto_err !== 1'b1 || busy !== 1'b1) begin
      n_errs++; $display("FAIL idle_read got sts=%b perr=%b busy=%b exp 11/1/1", to_sw_sig, proto_err, busy); end
    to_hw_sig = C_IDLE;
    tick(); tick();
    n_checks++; if (to_sw_sig !== S_ERR) begin n_errs++; $display("FAIL err_hold got %b exp 11", to_sw_sig); end
    to_hw_sig = C_ABORT;
    tick();
    to_hw_sig = C_IDLE;
    n_checks++; if (to_sw_sig !== S_IDLE || proto_err !== 1'b0 || busy !== 1'b0) begin
      n_errs++; $display("FAIL abort_clr got sts=%b perr=%b busy=%b exp 00/0/0", to_sw_sig, proto_err, busy); end
    tick();
  endtask

  // Full randomized exchange: write, stalled dispatch, result, read back
  task automatic run_txn(input int stall, input string tag);
    logic [31:0] w [4];
    logic [127:0] exp_msg, res;
    logic [31:0] rd;
    bit ok;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    exp_msg = pack4(w);
    for (int i = 0; i < 4; i++) begin
      sw_write(w[i], ok);
      n_checks++; if (!ok) begin n_errs++; $display("FAIL %s wr_handshake %0d got timeout exp ACK/IDLE", tag, i); end
    end
    repeat (stall) tick();
    n_checks++; if (msg_valid !== 1'b1 || msg_data !== exp_msg) begin
      n_errs++; $display("FAIL %s msg got v=%b d=%h exp v=1 d=%h", tag, msg_valid, msg_data, exp_msg); end
    msg_ready = 1;
    tick();
    msg_ready = 0;
    n_checks++; if (msg_valid !== 1'b0 || res_ready !== 1'b1) begin
      n_errs++; $display("FAIL %s accept got v=%b rr=%b exp 0/1", tag, msg_valid, res_ready); end
    res = {$urandom, $urandom, $urandom, $urandom};
    repeat (stall % 3) tick();
    res_data = res; res_valid = 1;
    tick();
    res_valid = 0;
    n_checks++; if (to_sw_sig !== S_RES || to_sw_port !== res[31:0]) begin
      n_errs++; $display("FAIL %s res_cap got sts=%b port=%h exp 10/%h", tag, to_sw_sig, to_sw_port, res[31:0]); end
    for (int i = 0; i < 4; i++) begin
      sw_read(rd, ok);
      n_checks++; if (!ok || rd !== res[i*32 +: 32]) begin
        n_errs++; $display("FAIL %s rd_word %0d got %h ok=%0d exp %h", tag, i, rd, ok, res[i*32 +: 32]); end
    end
    n_checks++; if (to_sw_sig !== S_IDLE || busy !== 1'b0) begin
      n_errs++; $display("FAIL %s done got sts=%b busy=%b exp 00/0", tag, to_sw_sig, busy); end
  endtask

  task automatic test_abort_wait();
    logic [31:0] w [4];
    bit ok;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    msg_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sw_write(w[i], ok);
      n_checks++; if (!ok) begin n_errs++; $display("FAIL ab_wr_handshake %0d got timeout exp ACK/IDLE", i); end
    end
    n_checks++; if (msg_valid !== 1'b1 || msg_data !== pack4(w)) begin
      n_errs++; $display("FAIL ab_msg got v=%b d=%h exp v=1 d=%h", msg_valid, msg_data, pack4(w)); end
    tick();
    msg_ready = 0;
    n_checks++; if (msg_valid !== 1'b0 || res_ready !== 1'b1) begin
      n_errs++; $display("FAIL one_cyc_dispatch got v=%b rr=%b exp 0/1", msg_valid, res_ready); end
    to_hw_sig = C_ABORT;
    tick();
    to_hw_sig = C_IDLE;
    tick(); tick();
    n_checks++; if (busy !== 1'b1 || res_ready !== 1'b1 || to_sw_sig !== S_IDLE) begin
      n_errs++; $display("FAIL ab_pending got busy=%b rr=%b sts=%b exp 1/1/00", busy, res_ready, to_sw_sig); end
    res_data = {$urandom, $urandom, $urandom, $urandom}; res_valid = 1;
    tick();
    res_valid = 0;
    n_checks++; if (res_ready !== 1'b0 || to_sw_sig !== S_IDLE || to_sw_port !== 32'h0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      n_errs++; $display("FAIL ab_discard got rr=%b sts=%b port=%h busy=%b perr=%b exp 0/00/0/0/0",
                         res_ready, to_sw_sig, to_sw_port, busy, proto_err); end
    repeat (2) tick();
    n_checks++; if (to_sw_sig !== S_IDLE) begin n_errs++; $display("FAIL ab_quiet got %b exp 00", to_sw_sig); end
    run_txn(1, "after_abort");
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 2; i++) begin
      sw_write($urandom, ok);
      n_checks++; if (!ok) begin n_errs++; $display("FAIL mid_wr_handshake %0d got timeout exp ACK/IDLE", i); end
    end
    Reset = 1;
    tick();
    Reset = 0;
    n_checks++; if (msg_data !== 128'h0 || to_sw_sig !== S_IDLE || to_sw_port !== 32'h0 ||
                    {msg_valid, res_ready, busy, proto_err} !== 4'b0) begin
      n_errs++; $display("FAIL mid_rst got msg=%h sts=%b port=%h flags=%b exp all 0",
                         msg_data, to_sw_sig, to_sw_port, {msg_valid, res_ready, busy, proto_err}); end
    run_txn(2, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) run_txn($urandom_range(0, 5), "random");
  endtask

  initial begin
    test_reset();
    test_write_msg();
    test_dispatch_stall();
    test_result_read();
    test_read_in_idle();
    test_abort_wait();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
